// File: rtl/uart_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_alu_pkg
// Description : Shared definitions for the UART ALU serial blocks: UART frame
//               constants, serializer and packet FSM state encodings, and the
//               baud divider helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package uart_alu_pkg;

   // UART frame shape (8N1)
   localparam int unsigned DATA_BITS = 8;
   localparam int unsigned STOP_BITS = 1;

   // Serializer FSM states
   localparam logic [1:0] TX_IDLE  = 2'd0;
   localparam logic [1:0] TX_START = 2'd1;
   localparam logic [1:0] TX_DATA  = 2'd2;
   localparam logic [1:0] TX_STOP  = 2'd3;

   // Packet FSM states
   localparam logic [1:0] PKT_IDLE = 2'd0;
   localparam logic [1:0] PKT_SEND = 2'd1;
   localparam logic [1:0] PKT_WAIT = 2'd2;

   // Clock cycles per bit, truncated.
   function automatic int unsigned calc_div(input int unsigned clk_freq_hz,
                                            input int unsigned baud_rate);
      return clk_freq_hz / baud_rate;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_byte
// Description : Single-byte UART serializer (start bit, DATA_BITS data bits
//               LSB first, STOP_BITS stop bits). Every bit lasts DIV cycles.
//               The data byte is captured on the start pulse so the caller
//               may change data_i afterwards.
// Ports       : clk     - core clock, rising edge
//               rst     - synchronous active-high reset
//               start_i - one-cycle request, honoured only while idle
//               data_i  - byte to send, sampled with start_i
//               tx_o    - serial output, idle high, driven from a flop
//               done_o  - high during the last cycle of the final stop bit
//               busy_o  - a frame is in progress
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_byte
   import uart_alu_pkg::*;
#(
   parameter int unsigned DIV = 217
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   input  logic [DATA_BITS-1:0] data_i,
   output logic                 tx_o,
   output logic                 done_o,
   output logic                 busy_o
);

   generate
      if (DIV < 2) begin : g_div_too_small
         $error("uart_tx_byte: DIV must be at least 2");
      end
   endgenerate

   localparam int unsigned      CNT_W     = (DIV < 2) ? 1 : $clog2(DIV);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
   localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
   localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

   logic [1:0]           state_q, state_d;
   logic [CNT_W-1:0]     baud_cnt_q, baud_cnt_d;
   logic [2:0]           bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 tx_q, tx_d;
   logic                 baud_last;

   assign baud_last = (baud_cnt_q == CNT_LAST);

   always_comb begin
      state_d    = state_q;
      baud_cnt_d = baud_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      tx_d       = tx_q;
      case (state_q)
         TX_IDLE: begin
            baud_cnt_d = '0;
            bit_cnt_d  = '0;
            tx_d       = 1'b1;
            if (start_i) begin
               state_d = TX_START;
               tx_d    = 1'b0;
               shift_d = data_i;
            end
         end
         TX_START: begin
            if (baud_last) begin
               baud_cnt_d = '0;
               bit_cnt_d  = '0;
               state_d    = TX_DATA;
               tx_d       = shift_q[0];
               shift_d    = {1'b0, shift_q[DATA_BITS-1:1]};
            end else begin
               baud_cnt_d = baud_cnt_q + 1'b1;
            end
         end
         TX_DATA: begin
            if (baud_last) begin
               baud_cnt_d = '0;
               if (bit_cnt_q == DATA_LAST) begin
                  bit_cnt_d = '0;
                  state_d   = TX_STOP;
                  tx_d      = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
                  tx_d      = shift_q[0];
                  shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
               end
            end else begin
               baud_cnt_d = baud_cnt_q + 1'b1;
            end
         end
         TX_STOP: begin
            // Line stays high; the bit counter now counts stop bits.
            if (baud_last) begin
               baud_cnt_d = '0;
               if (bit_cnt_q == STOP_LAST) begin
                  bit_cnt_d = '0;
                  state_d   = TX_IDLE;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end else begin
               baud_cnt_d = baud_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = TX_IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= TX_IDLE;
         baud_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
      end else begin
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
      end
   end

   assign tx_o   = tx_q;
   assign busy_o = (state_q != TX_IDLE);
   assign done_o = (state_q == TX_STOP) && baud_last && (bit_cnt_q == STOP_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_alu_resp_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_alu_resp_tx
// Description : UART ALU response transmitter. Accepts a 32-bit result over a
//               valid/ready handshake and sends BYTES bytes, least-significant
//               first, as 8N1 frames separated by a fixed 2-cycle idle gap.
//               Build option UART_RESP_CHECKSUM_EN appends one byte holding
//               the XOR of all result bytes sent.
// Ports       : clk      - core clock, rising edge
//               rst      - synchronous active-high reset
//               result_i - ALU result, sampled on handshake
//               valid_i  - result_i is valid
//               ready_o  - block can accept a result
//               busy_o   - a response is in flight
//               tx_o     - UART serial output, idle high
// Revision    : 1.0 - initial release
// ============================================================================
module uart_alu_resp_tx
   import uart_alu_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ = 25000000,
   parameter int unsigned BAUD_RATE   = 115200,
   parameter int unsigned BYTES       = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] result_i,
   input  logic        valid_i,
   output logic        ready_o,
   output logic        busy_o,
   output logic        tx_o
);

   localparam int unsigned DIV = calc_div(CLK_FREQ_HZ, BAUD_RATE);

   generate
      if (BYTES < 1 || BYTES > 4) begin : g_bytes_out_of_range
         $error("uart_alu_resp_tx: BYTES must be in 1..4");
      end
   endgenerate

`ifdef UART_RESP_CHECKSUM_EN
   // The checksum byte occupies index BYTES, after the result bytes.
   localparam logic [2:0] LAST_IDX = 3'(BYTES);
`else
   localparam logic [2:0] LAST_IDX = 3'(BYTES - 1);
`endif

   logic [1:0]  state_q, state_d;
   logic [2:0]  byte_idx_q, byte_idx_d;
   logic [31:0] shreg_q, shreg_d;
   logic        start_q, start_d;
   logic [7:0]  tx_data_q, tx_data_d;
`ifdef UART_RESP_CHECKSUM_EN
   logic [7:0]  csum_q, csum_d;
`endif
   logic        ser_done;
   logic        ser_busy;

   // The start pulse to the serializer is registered; together with the
   // serializer's own output flop this gives the fixed 2-cycle lead-in
   // before each start bit.
   always_comb begin
      state_d    = state_q;
      byte_idx_d = byte_idx_q;
      shreg_d    = shreg_q;
      start_d    = 1'b0;
      tx_data_d  = tx_data_q;
`ifdef UART_RESP_CHECKSUM_EN
      csum_d     = csum_q;
`endif
      case (state_q)
         PKT_IDLE: begin
            if (valid_i && ready_o) begin
               shreg_d    = result_i;
               byte_idx_d = '0;
               state_d    = PKT_SEND;
`ifdef UART_RESP_CHECKSUM_EN
               csum_d     = '0;
`endif
            end
         end
         PKT_SEND: begin
            start_d   = 1'b1;
            tx_data_d = shreg_q[7:0];
`ifdef UART_RESP_CHECKSUM_EN
            if (byte_idx_q == LAST_IDX) begin
               tx_data_d = csum_q;
            end else begin
               csum_d = csum_q ^ shreg_q[7:0];
            end
`endif
            state_d = PKT_WAIT;
         end
         PKT_WAIT: begin
            if (ser_done) begin
               shreg_d = {8'h00, shreg_q[31:8]};
               if (byte_idx_q == LAST_IDX) begin
                  state_d = PKT_IDLE;
               end else begin
                  byte_idx_d = byte_idx_q + 1'b1;
                  state_d    = PKT_SEND;
               end
            end
         end
         default: begin
            state_d = PKT_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= PKT_IDLE;
         byte_idx_q <= '0;
         shreg_q    <= '0;
         start_q    <= 1'b0;
         tx_data_q  <= '0;
`ifdef UART_RESP_CHECKSUM_EN
         csum_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         byte_idx_q <= byte_idx_d;
         shreg_q    <= shreg_d;
         start_q    <= start_d;
         tx_data_q  <= tx_data_d;
`ifdef UART_RESP_CHECKSUM_EN
         csum_q     <= csum_d;
`endif
      end
   end

   uart_tx_byte #(
      .DIV (DIV)
   ) u_tx_byte (
      .clk     (clk),
      .rst     (rst),
      .start_i (start_q),
      .data_i  (tx_data_q),
      .tx_o    (tx_o),
      .done_o  (ser_done),
      .busy_o  (ser_busy)
   );

   // The serializer is always idle when the packet FSM is idle; including
   // it keeps the handshake safe should that ever stop holding.
   assign ready_o = (state_q == PKT_IDLE) && !ser_busy;
   assign busy_o  = !ready_o;

endmodule
`default_nettype wire

// File: tb/tb_uart_alu_resp_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_alu_resp_tx
// Description : Directed self-checking bench for uart_alu_resp_tx at
//               CLK_FREQ_HZ=1000, BAUD_RATE=100 (10 cycles per bit).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_alu_resp_tx;

   localparam int FRAME = 102;  // 10 bits * 10 cycles + 2 gap cycles
`ifdef UART_RESP_CHECKSUM_EN
   localparam int NB = 5;
`else
   localparam int NB = 4;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] result_i = '0;
   logic        valid_i = 1'b0;
   logic        ready_o;
   logic        busy_o;
   logic        tx_o;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   logic [7:0] rx_byte  [0:15];
   int         rx_start [0:15];
   logic       rx_ok    [0:15];

   uart_alu_resp_tx #(
      .CLK_FREQ_HZ (1000),
      .BAUD_RATE   (100),
      .BYTES       (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .result_i (result_i),
      .valid_i  (valid_i),
      .ready_o  (ready_o),
      .busy_o   (busy_o),
      .tx_o     (tx_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Waits (bounded) for a start bit, then samples every bit mid-period.
   task automatic capture(input int idx);
      logic [7:0] d;
      logic       ok;
      int         waited;
      waited = 0;
      while (tx_o !== 1'b0 && waited < 400) begin
         @(posedge clk); #1;
         waited++;
      end
      ok = (tx_o === 1'b0);
      rx_start[idx] = cyc;
      repeat (4) begin @(posedge clk); #1; end
      if (tx_o !== 1'b0) ok = 1'b0;
      for (int b = 0; b < 8; b++) begin
         repeat (10) begin @(posedge clk); #1; end
         d[b] = tx_o;
      end
      repeat (10) begin @(posedge clk); #1; end
      if (tx_o !== 1'b1) ok = 1'b0;
      rx_byte[idx] = d;
      rx_ok[idx]   = ok;
   endtask

   task automatic wait_ready(output int c);
      int waited;
      waited = 0;
      while (ready_o !== 1'b1 && waited < 1000) begin
         @(posedge clk); #1;
         waited++;
      end
      c = (ready_o === 1'b1) ? cyc : -1;
   endtask

   task automatic send(input logic [31:0] v, output int acc);
      result_i = v;
      valid_i  = 1'b1;
      @(posedge clk); #1;
      acc     = cyc;
      valid_i = 1'b0;
   endtask

   task automatic test_reset();
      int bad;
      rst = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      n_checks++;
      if (tx_o !== 1'b1) $display("FAIL reset_tx: got %b expected 1", tx_o);
      else n_pass++;
      n_checks++;
      if (ready_o !== 1'b1) $display("FAIL reset_ready: got %b expected 1", ready_o);
      else n_pass++;
      n_checks++;
      if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy_o);
      else n_pass++;
      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (tx_o !== 1'b1 || ready_o !== 1'b1 || busy_o !== 1'b0) bad++;
      end
      n_checks++;
      if (bad != 0) $display("FAIL reset_idle: got %0d bad idle cycles expected 0", bad);
      else n_pass++;
   endtask

   task automatic test_single();
      logic [7:0] exp_b [5];
      int acc;
      int r;
      exp_b = '{8'h81, 8'h0F, 8'hC3, 8'hA5, 8'hE8};
      send(32'hA5C3_0F81, acc);
      n_checks++;
      if (ready_o !== 1'b0 || busy_o !== 1'b1)
         $display("FAIL single_accept: got ready=%b busy=%b expected ready=0 busy=1", ready_o, busy_o);
      else n_pass++;
      for (int k = 0; k < NB; k++) capture(k);
      for (int k = 0; k < NB; k++) begin
         n_checks++;
         if (rx_byte[k] !== exp_b[k])
            $display("FAIL single_byte%0d: got %02h expected %02h", k, rx_byte[k], exp_b[k]);
         else n_pass++;
         n_checks++;
         if (rx_ok[k] !== 1'b1) $display("FAIL single_frame%0d: got framing_ok=%b expected 1", k, rx_ok[k]);
         else n_pass++;
         n_checks++;
         if (rx_start[k] != acc + 2 + k * FRAME)
            $display("FAIL single_start%0d: got cycle %0d expected %0d", k, rx_start[k], acc + 2 + k * FRAME);
         else n_pass++;
      end
      wait_ready(r);
      n_checks++;
      if (r != acc + NB * FRAME)
         $display("FAIL single_ready_time: got cycle %0d expected %0d", r, acc + NB * FRAME);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_b [10];
      int acc1;
      int acc2;
      int r;
      int bad;
      exp_b = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};
      result_i = 32'h0000_0001;
      valid_i  = 1'b1;
      @(posedge clk); #1;
      acc1     = cyc;
      result_i = 32'hFFFF_FFFF;
      for (int k = 0; k < NB; k++) capture(k);
      wait_ready(r);
      n_checks++;
      if (r != acc1 + NB * FRAME)
         $display("FAIL b2b_ready_time: got cycle %0d expected %0d", r, acc1 + NB * FRAME);
      else n_pass++;
      @(posedge clk); #1;
      acc2 = cyc;
      n_checks++;
      if (ready_o !== 1'b0 || busy_o !== 1'b1)
         $display("FAIL b2b_second_accept: got ready=%b busy=%b expected ready=0 busy=1", ready_o, busy_o);
      else n_pass++;
      valid_i = 1'b0;
      for (int k = 0; k < NB; k++) capture(NB + k);
      for (int f = 0; f < 2; f++) begin
         for (int k = 0; k < NB; k++) begin
            n_checks++;
            if (rx_byte[f * NB + k] !== exp_b[f * 5 + k] || rx_ok[f * NB + k] !== 1'b1)
               $display("FAIL b2b_byte%0d_%0d: got %02h ok=%b expected %02h ok=1", f, k,
                        rx_byte[f * NB + k], rx_ok[f * NB + k], exp_b[f * 5 + k]);
            else n_pass++;
         end
      end
      n_checks++;
      if (rx_start[NB] != acc2 + 2)
         $display("FAIL b2b_second_start: got cycle %0d expected %0d", rx_start[NB], acc2 + 2);
      else n_pass++;
      wait_ready(r);
      bad = 0;
      for (int i = 0; i < 150; i++) begin
         @(posedge clk); #1;
         if (tx_o !== 1'b1 || ready_o !== 1'b1) bad++;
      end
      n_checks++;
      if (bad != 0) $display("FAIL b2b_no_extra: got %0d non-idle cycles expected 0", bad);
      else n_pass++;
   endtask

   task automatic test_ignore_busy();
      logic [7:0] exp_b [5];
      int acc;
      int r;
      int bad;
      exp_b = '{8'h12, 8'h96, 8'h5A, 8'h3C, 8'hE2};
      send(32'h3C5A_9612, acc);
      fork
         begin
            for (int k = 0; k < NB; k++) capture(k);
         end
         begin
            repeat (49) begin @(posedge clk); #1; end
            result_i = 32'hDEAD_BEEF;
            valid_i  = 1'b1;
            @(posedge clk); #1;
            valid_i = 1'b0;
            repeat (149) begin @(posedge clk); #1; end
            result_i = 32'h0BAD_F00D;
            valid_i  = 1'b1;
            @(posedge clk); #1;
            valid_i = 1'b0;
         end
      join
      for (int k = 0; k < NB; k++) begin
         n_checks++;
         if (rx_byte[k] !== exp_b[k] || rx_ok[k] !== 1'b1)
            $display("FAIL ignore_byte%0d: got %02h ok=%b expected %02h ok=1", k, rx_byte[k], rx_ok[k], exp_b[k]);
         else n_pass++;
      end
      wait_ready(r);
      n_checks++;
      if (r != acc + NB * FRAME)
         $display("FAIL ignore_ready_time: got cycle %0d expected %0d", r, acc + NB * FRAME);
      else n_pass++;
      bad = 0;
      for (int i = 0; i < 150; i++) begin
         @(posedge clk); #1;
         if (tx_o !== 1'b1 || ready_o !== 1'b1) bad++;
      end
      n_checks++;
      if (bad != 0) $display("FAIL ignore_no_second: got %0d non-idle cycles expected 0", bad);
      else n_pass++;
   endtask

   task automatic test_reset_midframe();
      logic [7:0] exp_b [5];
      int acc;
      int r;
      int bad;
      exp_b = '{8'h55, 8'h00, 8'h00, 8'h00, 8'h55};
      send(32'h1234_00AB, acc);
      // Byte 1 start bit begins at acc+104; data bit 3 spans acc+144..acc+153.
      repeat (149) begin @(posedge clk); #1; end
      n_checks++;
      if (tx_o !== 1'b0) $display("FAIL midframe_bit3: got %b expected 0", tx_o);
      else n_pass++;
      rst = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (tx_o !== 1'b1 || ready_o !== 1'b1 || busy_o !== 1'b0)
         $display("FAIL midframe_reset: got tx=%b ready=%b busy=%b expected tx=1 ready=1 busy=0",
                  tx_o, ready_o, busy_o);
      else n_pass++;
      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (tx_o !== 1'b1 || ready_o !== 1'b1) bad++;
      end
      n_checks++;
      if (bad != 0) $display("FAIL midframe_abandon: got %0d non-idle cycles expected 0", bad);
      else n_pass++;
      send(32'h0000_0055, acc);
      for (int k = 0; k < NB; k++) capture(k);
      for (int k = 0; k < NB; k++) begin
         n_checks++;
         if (rx_byte[k] !== exp_b[k] || rx_ok[k] !== 1'b1)
            $display("FAIL midframe_byte%0d: got %02h ok=%b expected %02h ok=1", k, rx_byte[k], rx_ok[k], exp_b[k]);
         else n_pass++;
      end
      n_checks++;
      if (rx_start[0] != acc + 2)
         $display("FAIL midframe_start: got cycle %0d expected %0d", rx_start[0], acc + 2);
      else n_pass++;
      wait_ready(r);
      n_checks++;
      if (r != acc + NB * FRAME)
         $display("FAIL midframe_ready_time: got cycle %0d expected %0d", r, acc + NB * FRAME);
      else n_pass++;
   endtask

`ifdef UART_RESP_CHECKSUM_EN
   task automatic test_checksum();
      logic [7:0] exp_b [5];
      int acc;
      int r;
      exp_b = '{8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
      send(32'h1234_5678, acc);
      for (int k = 0; k < 5; k++) capture(k);
      for (int k = 0; k < 5; k++) begin
         n_checks++;
         if (rx_byte[k] !== exp_b[k] || rx_ok[k] !== 1'b1)
            $display("FAIL csum_byte%0d: got %02h ok=%b expected %02h ok=1", k, rx_byte[k], rx_ok[k], exp_b[k]);
         else n_pass++;
      end
      wait_ready(r);
      n_checks++;
      if (r != acc + 510)
         $display("FAIL csum_ready_time: got cycle %0d expected %0d", r, acc + 510);
      else n_pass++;
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_ignore_busy();
      test_reset_midframe();
`ifdef UART_RESP_CHECKSUM_EN
      test_checksum();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
